// File: rtl/uart_pkg.sv
// Shared register-map constants and the frame state type used by both
// the receive and transmit sides of uart_mmio.
package uart_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int unsigned ST_TX_READY = 0;
  localparam int unsigned ST_RX_AVAIL = 1;
  localparam int unsigned ST_OVF      = 2;
  localparam int unsigned ST_FERR     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. A push is refused when
// full even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: 16x oversampled receiver and transmitter,
// each buffered by a sync_fifo, with DATA and STATUS registers.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        txd,
  input  logic        reg_sel,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] baud_cnt;
  logic          tick;
  logic          rxd_meta, rxd_s;
  uart_state_e   rx_state, tx_state;
  logic [3:0]    rx_sub, tx_sub;
  logic [2:0]    rx_idx, tx_idx;
  logic [7:0]    rx_shift, tx_shift;
  logic          ovf, ferr;
  logic          rx_done, rx_push, rx_pop, rx_full, rx_empty;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    rx_head, tx_head;
  logic          ovf_set, ferr_set, st_clr;

  assign tick = (baud_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) baud_cnt <= '0;
    else             baud_cnt <= baud_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Mid-bit sampling: half a bit after the start edge, then every 16 ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_sub   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        IDLE: if (!rxd_s) begin
          rx_state <= START;
          rx_sub   <= '0;
        end
        START: if (tick) begin
          if (rx_sub == 4'd7) begin
            rx_sub   <= '0;
            rx_idx   <= '0;
            rx_state <= rxd_s ? IDLE : DATA;
          end else rx_sub <= rx_sub + 4'd1;
        end
        DATA: if (tick) begin
          if (rx_sub == 4'd15) begin
            rx_sub   <= '0;
            rx_shift <= {rxd_s, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else rx_sub <= rx_sub + 4'd1;
        end
        STOP: if (tick) begin
          if (rx_sub == 4'd15) begin
            rx_sub   <= '0;
            rx_state <= IDLE;
          end else rx_sub <= rx_sub + 4'd1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  assign rx_done  = (rx_state == STOP) && tick && (rx_sub == 4'd15);
  assign rx_push  = rx_done & rxd_s & ~rx_full;
  assign ovf_set  = rx_done & rxd_s & rx_full;
  assign ferr_set = rx_done & ~rxd_s;
  assign st_clr   = rd_en & (reg_sel == REG_STATUS);
  assign rx_pop   = rd_en & (reg_sel == REG_DATA);
  assign tx_push  = wr_en & (reg_sel == REG_DATA);
  assign tx_pop   = (tx_state == IDLE) & ~tx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (ovf_set)     ovf <= 1'b1;
      else if (st_clr) ovf <= 1'b0;
      if (ferr_set)    ferr <= 1'b1;
      else if (st_clr) ferr <= 1'b0;
    end
  end

  // txd is registered; the shift register moves right so bit 1 is next out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_sub   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: if (tx_pop) begin
          tx_shift <= tx_head;
          tx_sub   <= '0;
          tx_state <= START;
          txd      <= 1'b0;
        end
        START: if (tick) begin
          if (tx_sub == 4'd15) begin
            tx_sub   <= '0;
            tx_idx   <= '0;
            tx_state <= DATA;
            txd      <= tx_shift[0];
          end else tx_sub <= tx_sub + 4'd1;
        end
        DATA: if (tick) begin
          if (tx_sub == 4'd15) begin
            tx_sub <= '0;
            if (tx_idx == 3'd7) begin
              tx_state <= STOP;
              txd      <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
            end
          end else tx_sub <= tx_sub + 4'd1;
        end
        STOP: if (tick) begin
          if (tx_sub == 4'd15) begin
            tx_sub   <= '0;
            tx_state <= IDLE;
          end else tx_sub <= tx_sub + 4'd1;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_shift),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_comb begin
    rdata = '0;
    if (reg_sel == REG_DATA) begin
      if (!rx_empty) rdata[7:0] = rx_head;
    end else begin
      rdata[ST_TX_READY] = ~tx_full;
      rdata[ST_RX_AVAIL] = ~rx_empty;
      rdata[ST_OVF]      = ovf;
      rdata[ST_FERR]     = ferr;
    end
  end

endmodule
